// File: rtl/c_drain_ctrl_if.sv
// c_drain_ctrl_if: valid/ready word stream that carries drained C words
// toward the host/DMA side.
//
// Signals
//   valid  word valid (master -> slave)
//   data   C word     (master -> slave)
//   last   marks the final word of a drain (master -> slave)
//   ready  consumer ready (slave -> master)
//
// Modports
//   master  the drain controller
//   slave   the stream consumer
interface c_drain_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              last;
    logic              ready;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/c_drain_ctrl.sv
// c_drain_ctrl: reads matrix C out of the C-buffer (port A, 1-cycle read
// latency) and streams it as valid/ready words. A 2-entry output FIFO plus a
// read credit absorbs RAM latency and downstream backpressure.
//
// Optional feature: define C_DRAIN_CLEAR_EN to zero-fill C[0..n-1] through
// port B after the stream has fully drained. Without it port B is tied off.
//
// Ports
//   clock     single clock for the controller and the C-buffer
//   reset     synchronous, active-high
//   start     1-cycle pulse, begins a drain from address 0 (ignored while busy)
//   len       words to drain, sampled on start; clamped to DEPTH
//   busy      high from the cycle after an accepted start until done
//   done      1-cycle completion pulse
//   c_addr_a  port A read address (registered inside the RAM)
//   c_q_a     port A read data, valid the cycle after the address
//   c_addr_b  port B address for clear writes
//   c_data_b  port B write data (always zero)
//   c_wren_b  port B write enable
//   m         stream master (valid/data/last out, ready in)
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start
// READ  | issuing port A reads while the read credit allows
// FLUSH | all reads issued, waiting for the FIFO to drain to the consumer
// CLEAR | writing zeros to C[0..n-1] via port B (C_DRAIN_CLEAR_EN only)
// DONE  | one-cycle done pulse, back to IDLE
module c_drain_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] c_addr_a,
    input  logic [DATA_W-1:0] c_q_a,
    output logic [ADDR_W-1:0] c_addr_b,
    output logic [DATA_W-1:0] c_data_b,
    output logic              c_wren_b,
    c_drain_ctrl_if.master    m
);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

`ifdef C_DRAIN_CLEAR_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_FLUSH = 3'd2,
        S_CLEAR = 3'd3,
        S_DONE  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_FLUSH = 3'd2,
        S_DONE  = 3'd4
    } state_t;
`endif

    state_t            state;
    state_t            state_next;
    logic [ADDR_W:0]   n;
    logic [ADDR_W:0]   rd_ptr;
    logic [ADDR_W:0]   sent;
    logic [ADDR_W:0]   len_clamped;
    logic              inflight;
    logic [DATA_W-1:0] fifo_mem [2];
    logic              wr_idx;
    logic              rd_idx;
    logic [1:0]        fifo_count;
    logic [1:0]        occ;
    logic              head_valid;
    logic              pop;
    logic              credit_ok;
    logic              rd_en;
    logic              drained;
`ifdef C_DRAIN_CLEAR_EN
    logic [ADDR_W:0]   clr_ptr;
`endif

    assign len_clamped = (len > DEPTH_C) ? DEPTH_C : len;
    assign head_valid  = (fifo_count != 2'd0);
    assign pop         = head_valid && m.ready;
    assign occ         = fifo_count + {1'b0, inflight};
    // A word leaving the FIFO this cycle frees its slot at the same edge the
    // in-flight word lands, so a pop counts as credit; this keeps 1 word/cycle.
    assign credit_ok   = (occ < 2'd2) || pop;
    assign rd_en       = (state == S_READ) && (rd_ptr != n) && credit_ok;
    // Looks through this cycle's pop so done follows the last transfer directly.
    assign drained     = ((sent + {{ADDR_W{1'b0}}, pop}) == n) &&
                         (fifo_count == {1'b0, pop}) && !inflight;

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            // A zero-length drain still walks READ and FLUSH with nothing to
            // do, so its done lands where a first word would have appeared.
            S_IDLE:  if (start) state_next = S_READ;
            S_READ:  if (rd_ptr == n) state_next = S_FLUSH;
`ifdef C_DRAIN_CLEAR_EN
            S_FLUSH: if (drained) state_next = (n == '0) ? S_DONE : S_CLEAR;
            S_CLEAR: if (clr_ptr == n - ONE) state_next = S_DONE;
`else
            S_FLUSH: if (drained) state_next = S_DONE;
`endif
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != S_IDLE) && (state != S_DONE);
        done     = (state == S_DONE);
        c_addr_a = rd_ptr[ADDR_W-1:0];
        m.valid  = head_valid;
        m.data   = fifo_mem[rd_idx];
        m.last   = head_valid && (sent == n - ONE);
        c_data_b = '0;
`ifdef C_DRAIN_CLEAR_EN
        c_wren_b = (state == S_CLEAR);
        c_addr_b = (state == S_CLEAR) ? clr_ptr[ADDR_W-1:0] : '0;
`else
        c_wren_b = 1'b0;
        c_addr_b = '0;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            n           <= '0;
            rd_ptr      <= '0;
            sent        <= '0;
            inflight    <= 1'b0;
            wr_idx      <= 1'b0;
            rd_idx      <= 1'b0;
            fifo_count  <= 2'd0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
`ifdef C_DRAIN_CLEAR_EN
            clr_ptr     <= '0;
`endif
        end else begin
            inflight <= rd_en;
            if (state == S_IDLE && start) begin
                n      <= len_clamped;
                rd_ptr <= '0;
                sent   <= '0;
            end else begin
                if (rd_en) rd_ptr <= rd_ptr + ONE;
                if (pop)   sent   <= sent + ONE;
            end
            if (inflight) begin
                fifo_mem[wr_idx] <= c_q_a;
                wr_idx           <= ~wr_idx;
            end
            if (pop) rd_idx <= ~rd_idx;
            case ({inflight, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
`ifdef C_DRAIN_CLEAR_EN
            if (state == S_CLEAR) clr_ptr <= clr_ptr + ONE;
            else                  clr_ptr <= '0;
`endif
        end
    end
endmodule

// File: tb/tb_c_drain_ctrl.sv
// tb_c_drain_ctrl: directed bench for c_drain_ctrl. Models the C-buffer as a
// 256x32 RAM with registered port A address and a port B write port, preloaded
// with C[i] = i*3+1. Stream transfers are collected on the falling edge and
// compared against hand-computed values.
// Build with C_DRAIN_CLEAR_EN defined to exercise the zero-fill path.
module tb_c_drain_ctrl;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W:0]   len;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] c_addr_a;
    logic [DATA_W-1:0] c_q_a;
    logic [ADDR_W-1:0] c_addr_b;
    logic [DATA_W-1:0] c_data_b;
    logic              c_wren_b;
    logic              preload;

    c_drain_ctrl_if #(.DATA_W(DATA_W)) s_if ();

    c_drain_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(256)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .c_addr_a (c_addr_a),
        .c_q_a    (c_q_a),
        .c_addr_b (c_addr_b),
        .c_data_b (c_data_b),
        .c_wren_b (c_wren_b),
        .m        (s_if)
    );

    always #5 clock = ~clock;

    logic [31:0] cmem [256];
    int cyc = 0;

    always @(posedge clock) begin
        cyc   <= cyc + 1;
        c_q_a <= cmem[c_addr_a];
        if (preload) begin
            for (int i = 0; i < 256; i++) cmem[i] <= 32'(i * 3 + 1);
        end else if (c_wren_b) begin
            cmem[c_addr_b] <= c_data_b;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    logic [31:0] got_q [$];
    logic        got_last [$];
    int done_cnt        = 0;
    int done_cyc        = -1;
    int last_xfer_cyc   = -1;
    int first_valid_cyc = -1;
    int wren_cnt        = 0;
    int last_wr_cyc     = -1;

    // Stream monitor: records transfers and checks data holds while stalled.
    initial begin
        logic        prev_stall;
        logic [31:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", 32'(s_if.valid), 32'd1);
                    chk("stall_data", s_if.data, prev_data);
                end
                if (s_if.valid && first_valid_cyc < 0) first_valid_cyc = cyc;
                if (s_if.valid && s_if.ready) begin
                    got_q.push_back(s_if.data);
                    got_last.push_back(s_if.last);
                    last_xfer_cyc = cyc;
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (c_wren_b) begin
                    wren_cnt++;
                    last_wr_cyc = cyc;
                end
                prev_stall = s_if.valid && !s_if.ready;
                prev_data  = s_if.data;
            end
        end
    end

    // mode 0: ready always high
    // mode 1: ready toggles 1/0 with a 5-cycle stall in the middle
    // mode 2: ready high, a second start (len=4) is pulsed while busy
    task automatic drain(input int l, input int mode, input string tag, output int start_cyc);
        int  d0;
        bit  timed_out;
        got_q.delete();
        got_last.delete();
        first_valid_cyc = -1;
        @(posedge clock); #1;
        preload = 1'b1;
        @(posedge clock); #1;
        preload = 1'b0;
        d0      = done_cnt;
        start   = 1'b1;
        len     = 9'(l);
        @(posedge clock); #1;
        start     = 1'b0;
        start_cyc = cyc;
        timed_out = 1'b1;
        for (int k = 0; k < 600; k++) begin
            case (mode)
                1:       s_if.ready = (k >= 8 && k < 13) ? 1'b0 : (k % 2 == 0);
                2: begin
                    s_if.ready = 1'b1;
                    if (k == 3) begin
                        start = 1'b1;
                        len   = 9'd4;
                    end else begin
                        start = 1'b0;
                    end
                end
                default: s_if.ready = 1'b1;
            endcase
            @(posedge clock); #1;
            if (done_cnt != d0) begin
                timed_out = 1'b0;
                break;
            end
        end
        start      = 1'b0;
        s_if.ready = 1'b1;
        chk({tag, "_timeout"}, 32'(timed_out), 32'd0);
        chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic check_words(input int n_exp, input string tag);
        int n_got;
        n_got = got_q.size();
        chk({tag, "_count"}, 32'(n_got), 32'(n_exp));
        for (int i = 0; i < n_got && i < n_exp; i++) begin
            chk({tag, "_data"}, got_q[i], 32'(i * 3 + 1));
            chk({tag, "_last"}, 32'(got_last[i]), 32'(i == n_exp - 1));
        end
    endtask

    initial begin
        int  sc;
        int  w0;
        bit  reached;
        reset      = 1'b1;
        start      = 1'b0;
        len        = '0;
        preload    = 1'b1;
        s_if.ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        preload = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(s_if.valid), 32'd0);
        chk("rst_last", 32'(s_if.last), 32'd0);
        chk("rst_data", s_if.data, 32'd0);
        chk("rst_addr_a", 32'(c_addr_a), 32'd0);
        chk("rst_wren_b", 32'(c_wren_b), 32'd0);
        reset = 1'b0;

        // Full-rate drain of 16 words: 1,4,..,46 back to back.
        drain(16, 0, "t1", sc);
        check_words(16, "t1");
        chk("t1_first_valid", 32'(first_valid_cyc), 32'(sc + 2));
        chk("t1_back_to_back", 32'(last_xfer_cyc - first_valid_cyc), 32'd15);
`ifdef C_DRAIN_CLEAR_EN
        chk("t1_done_after_clear", 32'(done_cyc), 32'(last_wr_cyc + 1));
`else
        chk("t1_done_after_last", 32'(done_cyc), 32'(last_xfer_cyc + 1));
`endif
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // Backpressure: toggling ready and a 5-cycle stall, same sequence.
        drain(16, 1, "t2", sc);
        check_words(16, "t2");

        // Zero length: no words, done on the cycle a first word would show.
        drain(0, 0, "t3a", sc);
        chk("t3a_no_valid", 32'(first_valid_cyc), 32'hFFFF_FFFF);
        chk("t3a_count", 32'(got_q.size()), 32'd0);
        chk("t3a_done_cyc", 32'(done_cyc), 32'(sc + 2));

        // Over-length request is clamped to the 256-word buffer.
        drain(300, 0, "t3b", sc);
        check_words(256, "t3b");

        // Second start while busy is ignored.
        drain(16, 2, "t5", sc);
        check_words(16, "t5");
        repeat (4) @(posedge clock);
        #1;
        chk("t5_no_restart", 32'(busy), 32'd0);

        // Reset mid-drain after 5 words, then a fresh len=4 drain.
        got_q.delete();
        got_last.delete();
        @(posedge clock); #1;
        preload = 1'b1;
        @(posedge clock); #1;
        preload = 1'b0;
        start   = 1'b1;
        len     = 9'd16;
        @(posedge clock); #1;
        start   = 1'b0;
        reached = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clock); #1;
            if (got_q.size() >= 5) begin
                reached = 1'b1;
                break;
            end
        end
        chk("t4_reached_5", 32'(reached), 32'd1);
        w0    = done_cnt;
        reset = 1'b1;
        @(posedge clock); #1;
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_done", 32'(done), 32'd0);
        chk("t4_valid", 32'(s_if.valid), 32'd0);
        chk("t4_data", s_if.data, 32'd0);
        chk("t4_last", 32'(s_if.last), 32'd0);
        chk("t4_addr_a", 32'(c_addr_a), 32'd0);
        chk("t4_wren_b", 32'(c_wren_b), 32'd0);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("t4_no_done", 32'(done_cnt - w0), 32'd0);
        drain(4, 0, "t4b", sc);
        check_words(4, "t4b");

`ifdef C_DRAIN_CLEAR_EN
        // Drain 8 words, then zero-fill C[0..7]; C[8] keeps its value.
        w0 = wren_cnt;
        drain(8, 0, "t6", sc);
        check_words(8, "t6");
        chk("t6_writes", 32'(wren_cnt - w0), 32'd8);
        chk("t6_done_after_clear", 32'(done_cyc), 32'(last_wr_cyc + 1));
        for (int i = 0; i < 8; i++) chk("t6_zeroed", cmem[i], 32'd0);
        chk("t6_c8_kept", cmem[8], 32'd25);
`else
        chk("no_port_b_writes", 32'(wren_cnt), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
